// File: rtl/qdec_ctu_sched_pkg.sv
// Shared types for the CTU-level CABAC scheduler.
package qdec_ctu_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_RESTORE = 4'd2,
    S_SAO     = 4'd3,
    S_CQT     = 4'd4,
    S_SAVE    = 4'd5,
    S_EOS     = 4'd6,
    S_SUBSET  = 4'd7,
    S_REINIT  = 4'd8,
    S_ADVANCE = 4'd9,
    S_TRAIL   = 4'd10,
    S_DONE    = 4'd11,
    S_ERROR   = 4'd12
  } t_state_sched;

  // Copy direction for the WPP context mover.
  localparam logic COPY_SAVE    = 1'b0;  // ctx memory -> WPP storage
  localparam logic COPY_RESTORE = 1'b1;  // WPP storage -> ctx memory

endpackage

// File: rtl/qdec_ctu_sched_if.sv
// Handshake and memory-port bundle between the CTU scheduler and its neighbours.
interface qdec_ctu_sched_if #(
  parameter int CTX_AW = 10
);
  logic              init_req, init_done;
  logic              sao_start, sao_done;
  logic              cqt_start, cqt_done;
  logic              term_req, term_vld, term_bin;
  logic              arith_reinit, arith_rdy;
  logic [CTX_AW-1:0] ctx_addr;
  logic              ctx_re, ctx_we;
  logic [7:0]        ctx_wdata, ctx_rdata;
  logic [CTX_AW-1:0] wpp_addr;
  logic              wpp_re, wpp_we;
  logic [7:0]        wpp_wdata, wpp_rdata;

  modport master (
    output init_req, sao_start, cqt_start, term_req, arith_reinit,
    input  init_done, sao_done, cqt_done, term_vld, term_bin, arith_rdy,
    output ctx_addr, ctx_re, ctx_we, ctx_wdata, input ctx_rdata,
    output wpp_addr, wpp_re, wpp_we, wpp_wdata, input wpp_rdata
  );

  modport slave (
    input  init_req, sao_start, cqt_start, term_req, arith_reinit,
    output init_done, sao_done, cqt_done, term_vld, term_bin, arith_rdy,
    input  ctx_addr, ctx_re, ctx_we, ctx_wdata, output ctx_rdata,
    input  wpp_addr, wpp_re, wpp_we, wpp_wdata, output wpp_rdata
  );
endinterface

// File: rtl/qdec_ctx_copy.sv
// Pipelined context mover: reads one entry per cycle from the source memory and
// writes it to the destination one cycle later (1-cycle read latency).
module qdec_ctx_copy
  import qdec_ctu_sched_pkg::*;
#(
  parameter int CTX_AW  = 10,
  parameter int NUM_CTX = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              start,
  input  logic              dir,
  output logic              active,
  output logic              done,
  output logic [CTX_AW-1:0] ctx_addr,
  output logic              ctx_re,
  output logic              ctx_we,
  output logic [7:0]        ctx_wdata,
  input  logic [7:0]        ctx_rdata,
  output logic [CTX_AW-1:0] wpp_addr,
  output logic              wpp_re,
  output logic              wpp_we,
  output logic [7:0]        wpp_wdata,
  input  logic [7:0]        wpp_rdata
);
  localparam logic [CTX_AW-1:0] LAST = CTX_AW'(NUM_CTX - 1);

  logic              rd_busy, wr_vld, dir_q;
  logic [CTX_AW-1:0] rd_addr, wr_addr;

  // Read-address sweep with a one-cycle trailing write stage.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      rd_busy <= 1'b0;
      wr_vld  <= 1'b0;
      rd_addr <= '0;
      wr_addr <= '0;
      dir_q   <= COPY_SAVE;
    end else begin
      wr_vld  <= rd_busy;
      wr_addr <= rd_addr;
      if (start && !rd_busy && !wr_vld) begin
        rd_busy <= 1'b1;
        rd_addr <= '0;
        dir_q   <= dir;
      end else if (rd_busy) begin
        if (rd_addr == LAST) rd_busy <= 1'b0;
        else                 rd_addr <= rd_addr + CTX_AW'(1);
      end
    end
  end

  // Steer read/write strobes to the two memories by direction; idle ports read as zero.
  always_comb begin
    active    = rd_busy | wr_vld;
    done      = wr_vld & ~rd_busy;
    ctx_re    = rd_busy & (dir_q == COPY_SAVE);
    wpp_re    = rd_busy & (dir_q == COPY_RESTORE);
    ctx_we    = wr_vld & (dir_q == COPY_RESTORE);
    wpp_we    = wr_vld & (dir_q == COPY_SAVE);
    ctx_addr  = '0;
    wpp_addr  = '0;
    if (active) begin
      ctx_addr = (dir_q == COPY_RESTORE) ? wr_addr : rd_addr;
      wpp_addr = (dir_q == COPY_RESTORE) ? rd_addr : wr_addr;
    end
    ctx_wdata = ctx_we ? wpp_rdata : '0;
    wpp_wdata = wpp_we ? ctx_rdata : '0;
  end
endmodule

// File: rtl/qdec_ctu_sched.sv
// CTU-level CABAC scheduler: walks CTBs in raster order, sequencing ctx init,
// SAO, CQT, terminate bins and WPP context save/restore.
module qdec_ctu_sched
  import qdec_ctu_sched_pkg::*;
#(
  parameter int CTX_AW  = 10,
  parameter int NUM_CTX = 512,
  parameter int XW      = 7,
  parameter int YW      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [XW-1:0]         pic_w_ctb,
  input  logic [YW-1:0]         pic_h_ctb,
  input  logic                  sao_en,
  input  logic                  wpp_en,
  qdec_ctu_sched_if.master      bus,
  output logic                  ctx_own,
  output logic [XW-1:0]         x_ctb,
  output logic [YW-1:0]         y_ctb,
  output logic                  busy,
  output logic                  ctu_done_intr,
  output logic                  done_intr,
  output logic                  error_intr
);
  t_state_sched  state, state_nxt, ctu_first;
  logic          entry;
  logic          row_end, last_ctb;
  logic [XW-1:0] x_next;
  logic          copy_start, copy_done, copy_dir;

  qdec_ctx_copy #(.CTX_AW(CTX_AW), .NUM_CTX(NUM_CTX)) u_copy (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .start     (copy_start),
    .dir       (copy_dir),
    .active    (ctx_own),
    .done      (copy_done),
    .ctx_addr  (bus.ctx_addr),
    .ctx_re    (bus.ctx_re),
    .ctx_we    (bus.ctx_we),
    .ctx_wdata (bus.ctx_wdata),
    .ctx_rdata (bus.ctx_rdata),
    .wpp_addr  (bus.wpp_addr),
    .wpp_re    (bus.wpp_re),
    .wpp_we    (bus.wpp_we),
    .wpp_wdata (bus.wpp_wdata),
    .wpp_rdata (bus.wpp_rdata)
  );

  // Next-state selection; abort overrides every transition.
  always_comb begin
    row_end   = (x_ctb == pic_w_ctb);
    last_ctb  = row_end && (y_ctb == pic_h_ctb);
    x_next    = row_end ? '0 : x_ctb + XW'(1);
    ctu_first = sao_en ? S_SAO : S_CQT;
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_INIT;
      S_INIT:    if (bus.init_done) state_nxt = ctu_first;
      S_RESTORE: if (copy_done) state_nxt = ctu_first;
      S_SAO:     if (bus.sao_done) state_nxt = S_CQT;
      S_CQT:     if (bus.cqt_done)
                   state_nxt = (wpp_en && x_ctb == XW'(1)) ? S_SAVE : S_EOS;
      S_SAVE:    if (copy_done) state_nxt = S_EOS;
      S_EOS:     if (bus.term_vld) begin
                   if (bus.term_bin)         state_nxt = S_TRAIL;
                   else if (last_ctb)        state_nxt = S_ERROR;
                   else if (wpp_en && row_end) state_nxt = S_SUBSET;
                   else                      state_nxt = S_ADVANCE;
                 end
      S_SUBSET:  if (bus.term_vld) state_nxt = bus.term_bin ? S_REINIT : S_ERROR;
      S_REINIT:  if (bus.arith_rdy) state_nxt = S_ADVANCE;
      S_ADVANCE: if (wpp_en && x_next == '0)
                   state_nxt = (pic_w_ctb != '0) ? S_RESTORE : S_INIT;
                 else
                   state_nxt = ctu_first;
      S_TRAIL:   if (bus.arith_rdy) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // State, entry flag and CTB coordinate registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      entry <= 1'b0;
      x_ctb <= '0;
      y_ctb <= '0;
    end else begin
      state <= state_nxt;
      entry <= (state_nxt != state);
      if (!abort && state == S_IDLE && start) begin
        x_ctb <= '0;
        y_ctb <= '0;
      end else if (!abort && state == S_ADVANCE) begin
        x_ctb <= x_next;
        if (row_end) y_ctb <= y_ctb + YW'(1);
      end
    end
  end

  // Request pulses fire on the first cycle of their state.
  always_comb begin
    bus.init_req     = entry && state == S_INIT;
    bus.sao_start    = entry && state == S_SAO;
    bus.cqt_start    = entry && state == S_CQT;
    bus.term_req     = entry && (state == S_EOS || state == S_SUBSET);
    bus.arith_reinit = entry && (state == S_REINIT || state == S_TRAIL);
    copy_start       = entry && (state == S_SAVE || state == S_RESTORE);
    copy_dir         = (state == S_RESTORE) ? COPY_RESTORE : COPY_SAVE;
    ctu_done_intr    = (state == S_ADVANCE) || (entry && state == S_TRAIL);
    done_intr        = (state == S_DONE);
    error_intr       = entry && state == S_ERROR;
    busy             = (state != S_IDLE);
  end
endmodule

// File: tb/tb_qdec_ctu_sched.sv
// Self-checking bench for qdec_ctu_sched: event-sequence reference model,
// reactive sub-FSM responders and context/WPP memory models.
module tb_qdec_ctu_sched;
  localparam int CTX_AW  = 10;
  localparam int NUM_CTX = 512;
  localparam int XW      = 7;
  localparam int YW      = 6;
  localparam int BUDGET  = 20000;

  localparam int E_INIT = 1, E_SAO = 2, E_CQT = 3, E_SAVE = 4, E_RESTORE = 5;
  localparam int E_TERM = 6, E_REINIT = 7, E_CTU = 8, E_DONE = 9, E_ERROR = 10;

  logic clk = 1'b0;
  logic rst_n, start, abort, sao_en, wpp_en;
  logic [XW-1:0] pic_w_ctb;
  logic [YW-1:0] pic_h_ctb;
  logic ctx_own, busy, ctu_done_intr, done_intr, error_intr;
  logic [XW-1:0] x_ctb;
  logic [YW-1:0] y_ctb;

  qdec_ctu_sched_if #(.CTX_AW(CTX_AW)) bus ();

  qdec_ctu_sched #(.CTX_AW(CTX_AW), .NUM_CTX(NUM_CTX), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .pic_w_ctb(pic_w_ctb), .pic_h_ctb(pic_h_ctb), .sao_en(sao_en), .wpp_en(wpp_en),
    .bus(bus), .ctx_own(ctx_own), .x_ctb(x_ctb), .y_ctb(y_ctb), .busy(busy),
    .ctu_done_intr(ctu_done_intr), .done_intr(done_intr), .error_intr(error_intr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ev_q[$], exp_q[$];
  bit bin_q[$];
  bit eos_a[64], sub_a[64];
  bit mon_en = 0, spur_cqt = 0;
  int done_cnt = 0, err_cnt = 0;
  logic [7:0] ctx_mem [NUM_CTX];
  logic [7:0] wpp_mem [NUM_CTX];
  logic [7:0] snap    [NUM_CTX];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ev(input int code, input int x = 0, input int y = 0);
    return code * 65536 + y * 256 + x;
  endfunction

  // Expected event stream of one slice, walked CTB by CTB; also queues the bins to serve.
  function automatic void build_model(input int w, input int h, input bit sao, input bit wpp);
    exp_q = {};
    bin_q = {};
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        int i = y * w + x;
        if (x == 0) begin
          if (i == 0 || (wpp && w == 1)) exp_q.push_back(ev(E_INIT));
          else if (wpp)                  exp_q.push_back(ev(E_RESTORE));
        end
        if (sao) exp_q.push_back(ev(E_SAO, x, y));
        exp_q.push_back(ev(E_CQT, x, y));
        if (wpp && x == 1) exp_q.push_back(ev(E_SAVE));
        exp_q.push_back(ev(E_TERM));
        bin_q.push_back(eos_a[i]);
        if (eos_a[i]) begin
          exp_q.push_back(ev(E_REINIT));
          exp_q.push_back(ev(E_CTU));
          exp_q.push_back(ev(E_DONE));
          return;
        end
        if (i == w * h - 1) begin
          exp_q.push_back(ev(E_ERROR));
          return;
        end
        if (wpp && x == w - 1) begin
          exp_q.push_back(ev(E_TERM));
          bin_q.push_back(sub_a[i]);
          if (!sub_a[i]) begin
            exp_q.push_back(ev(E_ERROR));
            return;
          end
          exp_q.push_back(ev(E_REINIT));
        end
        exp_q.push_back(ev(E_CTU));
      end
    end
  endfunction

  // Context and WPP memories (1-cycle read); CQT completion rewrites contexts.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_mem[i] <= 8'($urandom);
        wpp_mem[i] <= 8'h00;
      end
    end else begin
      if (bus.ctx_re) bus.ctx_rdata <= ctx_mem[bus.ctx_addr];
      if (bus.wpp_re) bus.wpp_rdata <= wpp_mem[bus.wpp_addr];
      if (bus.ctx_we) ctx_mem[bus.ctx_addr] <= bus.ctx_wdata;
      if (bus.wpp_we) wpp_mem[bus.wpp_addr] <= bus.wpp_wdata;
      if (bus.cqt_done)
        for (int i = 0; i < NUM_CTX; i++) ctx_mem[i] <= 8'($urandom);
    end
  end

  // Monitor: turns DUT pulses into events and checks each completed copy burst.
  int  blen = 0, bsave = 0, brest = 0;
  bit  own_prev = 0;
  always @(negedge clk) begin
    if (done_intr)  done_cnt++;
    if (error_intr) err_cnt++;
    if (!mon_en) begin
      blen = 0; bsave = 0; brest = 0; own_prev = 0;
    end else begin
      if (ctx_own) begin
        blen++;
        if (bus.wpp_we) bsave++;
        if (bus.ctx_we) brest++;
      end else if (own_prev) begin
        int m = 0;
        chk("copy_len", blen, NUM_CTX + 1);
        if (bsave > 0) begin
          chk("save_writes", bsave, NUM_CTX);
          for (int i = 0; i < NUM_CTX; i++) if (wpp_mem[i] !== ctx_mem[i]) m++;
          chk("save_data_mism", m, 0);
          snap = ctx_mem;
          ev_q.push_back(ev(E_SAVE));
        end else begin
          chk("restore_writes", brest, NUM_CTX);
          for (int i = 0; i < NUM_CTX; i++) if (ctx_mem[i] !== snap[i]) m++;
          chk("restore_data_mism", m, 0);
          ev_q.push_back(ev(E_RESTORE));
        end
        blen = 0; bsave = 0; brest = 0;
      end
      own_prev = ctx_own;
      if (bus.init_req)     ev_q.push_back(ev(E_INIT));
      if (bus.sao_start)    ev_q.push_back(ev(E_SAO, int'(x_ctb), int'(y_ctb)));
      if (bus.cqt_start)    ev_q.push_back(ev(E_CQT, int'(x_ctb), int'(y_ctb)));
      if (bus.term_req)     ev_q.push_back(ev(E_TERM));
      if (bus.arith_reinit) ev_q.push_back(ev(E_REINIT));
      if (ctu_done_intr)    ev_q.push_back(ev(E_CTU));
      if (done_intr)        ev_q.push_back(ev(E_DONE));
      if (error_intr)       ev_q.push_back(ev(E_ERROR));
    end
  end

  // Sub-FSM responders: each request is answered after a random delay.
  int ic = 0, sc = 0, cc = 0, tc = 0, ac = 0;
  initial begin
    {bus.init_done, bus.sao_done, bus.cqt_done, bus.term_vld, bus.term_bin, bus.arith_rdy} = '0;
    bus.ctx_rdata = '0;
    bus.wpp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      {bus.init_done, bus.sao_done, bus.cqt_done, bus.term_vld, bus.term_bin, bus.arith_rdy} = '0;
      if (ic == 1) bus.init_done = 1'b1;
      if (ic > 0) ic--;
      if (bus.init_req) ic = $urandom_range(1, 3);
      if (spur_cqt && sc == 2) bus.cqt_done = 1'b1;
      if (sc == 1) bus.sao_done = 1'b1;
      if (sc > 0) sc--;
      if (bus.sao_start) sc = $urandom_range(2, 4);
      if (cc == 1) bus.cqt_done = 1'b1;
      if (cc > 0) cc--;
      if (bus.cqt_start) cc = $urandom_range(1, 4);
      if (tc == 1) begin
        bus.term_vld = 1'b1;
        bus.term_bin = (bin_q.size() > 0) ? bin_q.pop_front() : 1'b1;
      end
      if (tc > 0) tc--;
      if (bus.term_req) tc = $urandom_range(1, 3);
      if (ac == 1) bus.arith_rdy = 1'b1;
      if (ac > 0) ac--;
      if (bus.arith_reinit) ac = $urandom_range(1, 3);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one slice to done/error and compares the event stream with the model.
  task automatic run_slice(input string tag, input int w, input int h, input bit sao,
                           input bit wpp, input bit poke_start, input bit exp_err);
    int cyc = 0;
    int d0 = done_cnt, e0 = err_cnt;
    repeat (8) tick();
    build_model(w, h, sao, wpp);
    ev_q = {};
    mon_en = 1;
    pic_w_ctb = XW'(w - 1);
    pic_h_ctb = YW'(h - 1);
    sao_en = sao;
    wpp_en = wpp;
    start = 1; tick(); start = 0;
    if (poke_start) begin
      repeat (3) tick();
      start = 1; tick(); start = 0;
    end
    while (done_cnt == d0 && err_cnt == e0 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
    chk({tag, "_timeout"}, int'(cyc < BUDGET), 1);
    repeat (10) tick();
    chk({tag, "_ev_count"}, ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), ev_q[i], exp_q[i]);
    if (exp_err) begin
      chk({tag, "_err_once"}, err_cnt - e0, 1);
      chk({tag, "_err_hold_busy"}, int'(busy), 1);
      abort = 1; tick(); abort = 0;
      chk({tag, "_abort_idle"}, int'(busy), 0);
    end else begin
      chk({tag, "_done_once"}, done_cnt - d0, 1);
      chk({tag, "_idle_after"}, int'(busy), 0);
    end
    mon_en = 0;
  endtask

  initial begin
    int cyc;
    int w, h, d0;
    rst_n = 0; start = 0; abort = 0; sao_en = 0; wpp_en = 0;
    pic_w_ctb = '0; pic_h_ctb = '0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_x", int'(x_ctb), 0);
    chk("rst_y", int'(y_ctb), 0);
    chk("rst_ctx_own", int'(ctx_own), 0);
    chk("rst_pulses", int'({bus.init_req, bus.sao_start, bus.cqt_start, bus.term_req,
                           bus.arith_reinit, ctu_done_intr, done_intr, error_intr}), 0);
    chk("rst_mem_strobes", int'({bus.ctx_re, bus.ctx_we, bus.wpp_re, bus.wpp_we}), 0);

    // 2x2, SAO on, no WPP; spurious cqt_done during SAO and start while busy
    eos_a = '{default: 0}; sub_a = '{default: 1};
    eos_a[3] = 1;
    spur_cqt = 1;
    run_slice("t2x2_sao", 2, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    spur_cqt = 0;

    // 4x2 WPP: saves after (1,y), restore before (0,1)
    eos_a = '{default: 0}; eos_a[7] = 1;
    run_slice("t4x2_wpp", 4, 2, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);

    // 1x3 WPP: no save, INIT per row, subset bits + reinit
    eos_a = '{default: 0}; eos_a[2] = 1;
    run_slice("t1x3_wpp", 1, 3, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2x2 WPP with a zero end_of_subset bit
    eos_a = '{default: 0}; eos_a[3] = 1; sub_a[1] = 0;
    run_slice("t_subset0", 2, 2, 1'b1, 1'b1, 1'b0, 1'b1);
    sub_a = '{default: 1};

    // Last CTB without end_of_slice
    eos_a = '{default: 0};
    run_slice("t_last_eos0", 3, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized slices
    for (int r = 0; r < 5; r++) begin
      w = $urandom_range(1, 4);
      h = $urandom_range(1, 3);
      for (int i = 0; i < 64; i++) eos_a[i] = ($urandom_range(0, 11) == 0);
      eos_a[w * h - 1] = 1;
      run_slice($sformatf("rnd%0d", r), w, h, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Abort in the middle of RESTORE
    repeat (8) tick();
    eos_a = '{default: 0}; eos_a[3] = 1;
    build_model(2, 2, 1'b0, 1'b1);
    pic_w_ctb = XW'(1); pic_h_ctb = YW'(1); sao_en = 0; wpp_en = 1;
    start = 1; tick(); start = 0;
    cyc = 0;
    while (!bus.ctx_we && cyc < BUDGET) begin tick(); cyc++; end
    chk("abort_reach_restore", int'(cyc < BUDGET), 1);
    repeat (20) tick();
    d0 = done_cnt;
    abort = 1; tick(); abort = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ctx_own", int'(ctx_own), 0);
    chk("abort_ctx_we", int'(bus.ctx_we), 0);
    repeat (10) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_own_stays0", int'(ctx_own), 0);

    // Reset in the middle of CQT on CTB (1,0)
    repeat (8) tick();
    eos_a = '{default: 0}; eos_a[1] = 1;
    build_model(2, 1, 1'b0, 1'b0);
    pic_w_ctb = XW'(1); pic_h_ctb = '0; wpp_en = 0;
    start = 1; tick(); start = 0;
    cyc = 0;
    while (!(bus.cqt_start && x_ctb == XW'(1)) && cyc < BUDGET) begin tick(); cyc++; end
    chk("rstmid_reach_cqt", int'(cyc < BUDGET), 1);
    rst_n = 0; tick();
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_x", int'(x_ctb), 0);
    chk("rstmid_outs", int'({bus.init_req, bus.sao_start, bus.cqt_start, bus.term_req,
                            bus.arith_reinit, ctu_done_intr, done_intr, error_intr, ctx_own}), 0);
    rst_n = 1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
